// File: rtl/vcap_pkg.sv
// Shared definitions for the vcap ring scaler: FSM encoding, YCbCr->RGB
// coefficients/offsets and the write-path latencies for both build variants.
package vcap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLAIM,
    ST_CAPTURE,
    ST_SKIP,
    ST_DRAIN,
    ST_DONE
  } vcap_state_e;

  // Q2.8 BT.601 studio-swing coefficients
  localparam int C_Y   = 298;
  localparam int C_RCR = 409;
  localparam int C_GCR = 208;
  localparam int C_GCB = 100;
  localparam int C_BCB = 516;

  localparam int Y_OFS = 16;
  localparam int C_OFS = 128;

  localparam int unsigned PIPE_LAT_RGB = 3;
  localparam int unsigned PIPE_LAT_RAW = 1;

endpackage

// File: rtl/vcap_ycc2rgb565.sv
// Three-stage YCbCr -> RGB565 converter: multiply, sum, clamp/pack.
module vcap_ycc2rgb565
  import vcap_pkg::*;
(
  input  logic        clk_llc2,
  input  logic        resetx,
  input  logic        in_valid,
  input  logic [7:0]  y,
  input  logic [7:0]  cb,
  input  logic [7:0]  cr,
  output logic        out_valid,
  output logic [15:0] rgb
);

  logic signed [19:0] m_y, m_rcr, m_gcr, m_gcb, m_bcb;
  logic signed [19:0] s_r, s_g, s_b;
  logic               v1, v2;
  int                 y_t, cb_t, cr_t;

  function automatic logic [7:0] clamp8(input logic signed [19:0] v);
    logic signed [19:0] s;
    s = v >>> 8;
    if (s < 0)        clamp8 = '0;
    else if (s > 255) clamp8 = '1;
    else              clamp8 = 8'(s);
  endfunction

  always_comb begin
    y_t  = int'(y)  - Y_OFS;
    cb_t = int'(cb) - C_OFS;
    cr_t = int'(cr) - C_OFS;
  end

  always_ff @(posedge clk_llc2 or negedge resetx) begin
    if (!resetx) begin
      m_y <= '0; m_rcr <= '0; m_gcr <= '0; m_gcb <= '0; m_bcb <= '0;
      s_r <= '0; s_g <= '0; s_b <= '0;
      v1 <= 1'b0; v2 <= 1'b0; out_valid <= 1'b0;
      rgb <= '0;
    end else begin
      m_y   <= 20'(C_Y   * y_t);
      m_rcr <= 20'(C_RCR * cr_t);
      m_gcr <= 20'(C_GCR * cr_t);
      m_gcb <= 20'(C_GCB * cb_t);
      m_bcb <= 20'(C_BCB * cb_t);
      v1    <= in_valid;

      s_r <= m_y + m_rcr;
      s_g <= m_y - m_gcr - m_gcb;
      s_b <= m_y + m_bcb;
      v2  <= v1;

      rgb <= {5'(clamp8(s_r) >> 3), 6'(clamp8(s_g) >> 2), 5'(clamp8(s_b) >> 3)};
      out_valid <= v2;
    end
  end

endmodule

// File: rtl/vcap_ring_scaler.sv
// Video capture front-end: decimates YCbCr 4:2:2 fields into a ring of host-owned
// frame buffers. Define VCAP_RGB565_EN to write RGB565 instead of raw {Y,Cb}.
module vcap_ring_scaler
  import vcap_pkg::*;
#(
  parameter int H_ACTIVE   = 720,
  parameter int V_ACTIVE   = 240,
  parameter int H_DEC      = 4,
  parameter int V_DEC      = 2,
  parameter int NUM_BUF    = 3,
  parameter int FIELD_MODE = 0,
  localparam int H_OUT  = H_ACTIVE / H_DEC,
  localparam int V_OUT  = V_ACTIVE / V_DEC,
  localparam int BUF_AW = $clog2(H_OUT * V_OUT),
  localparam int IDX_W  = $clog2(NUM_BUF)
) (
  input  logic                    clk_llc2,
  input  logic                    resetx,
  input  logic                    vref,
  input  logic                    href,
  input  logic                    odd,
  input  logic [15:0]             vpo,
  input  logic                    buf_rel,
  input  logic [IDX_W-1:0]        buf_rel_idx,
  output logic                    wr_en,
  output logic [BUF_AW+IDX_W-1:0] wr_addr,
  output logic [15:0]             wr_data,
  output logic                    frame_rdy,
  output logic [IDX_W-1:0]        frame_idx,
  output logic                    frame_err,
  output logic [NUM_BUF-1:0]      buf_busy,
  output logic [7:0]              drop_cnt,
  output logic                    cap_active
);

`ifdef VCAP_RGB565_EN
  localparam int unsigned PIPE_LAT = PIPE_LAT_RGB;
`else
  localparam int unsigned PIPE_LAT = PIPE_LAT_RAW;
`endif

  localparam int XW  = $clog2(H_ACTIVE + 1);
  localparam int LW  = $clog2(V_ACTIVE + 1);
  localparam int XOW = $clog2(H_OUT + 1);
  localparam int LOW = $clog2(V_OUT + 1);
  localparam int AW  = BUF_AW + IDX_W;

  vcap_state_e state, state_nx;

  logic                       vref_d, href_d, odd_lat, pend;
  logic [XW-1:0]              x_cnt;
  logic [LW-1:0]              line_cnt;
  logic [XOW-1:0]             x_out;
  logic [LOW-1:0]             line_out;
  logic [IDX_W-1:0]           cur_idx, last_idx, free_idx, cand;
  logic [1:0]                 drain_cnt;
  logic [7:0]                 y_lat, cb_lat;
  logic [NUM_BUF-1:0]         rel_mask, busy_eff, set_mask;
  logic                       found, parity_ok, capturing, line_keep;
  logic                       pair_first, pair_fire, field_full, done_ok;
  logic [AW-1:0]              addr_now;
  logic [PIPE_LAT-1:0][AW-1:0] addr_sr;

  assign capturing  = (state == ST_CAPTURE);
  assign cap_active = capturing;
  assign parity_ok  = (FIELD_MODE == 2) || (FIELD_MODE == 0 && odd_lat) ||
                      (FIELD_MODE == 1 && !odd_lat);
  assign line_keep  = (32'(line_cnt) % V_DEC == 0) && (32'(line_cnt) < V_ACTIVE) &&
                      (32'(line_out) < V_OUT);
  assign pair_first = capturing && href && line_keep && (32'(x_cnt) % H_DEC == 0) &&
                      (32'(x_cnt) < H_ACTIVE) && (32'(x_out) < H_OUT);
  // the pair completes on the following pixel, which carries its Cr
  assign pair_fire  = capturing && href && pend;
  assign field_full = (32'(line_out) == V_OUT);
  assign done_ok    = (state == ST_DONE) && field_full;
  assign addr_now   = {cur_idx, BUF_AW'(32'(line_out) * H_OUT + 32'(x_out))};

  // a release in the same cycle as CLAIM frees the buffer before the search
  always_comb begin
    rel_mask = '0;
    if (buf_rel && (32'(buf_rel_idx) < NUM_BUF)) rel_mask[buf_rel_idx] = 1'b1;
    busy_eff = buf_busy & ~rel_mask;
    set_mask = '0;
    if (done_ok) set_mask[cur_idx] = 1'b1;
    found    = 1'b0;
    free_idx = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NUM_BUF; k++) begin
      cand = IDX_W'((32'(last_idx) + 1 + k) % NUM_BUF);
      if (!found && !busy_eff[cand]) begin
        found    = 1'b1;
        free_idx = cand;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (vref && !vref_d) state_nx = ST_CLAIM;
      ST_CLAIM:   state_nx = (parity_ok && found) ? ST_CAPTURE : ST_SKIP;
      ST_CAPTURE: if (!vref && vref_d) state_nx = ST_DRAIN;
      ST_SKIP:    if (!vref && vref_d) state_nx = ST_IDLE;
      ST_DRAIN:   if (32'(drain_cnt) == PIPE_LAT - 1) state_nx = ST_DONE;
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_llc2 or negedge resetx) begin
    if (!resetx) begin
      state     <= ST_IDLE;
      vref_d    <= 1'b0;
      href_d    <= 1'b0;
      odd_lat   <= 1'b0;
      pend      <= 1'b0;
      x_cnt     <= '0;
      x_out     <= '0;
      line_cnt  <= '0;
      line_out  <= '0;
      drain_cnt <= '0;
      y_lat     <= '0;
      cb_lat    <= '0;
    end else begin
      state  <= state_nx;
      vref_d <= vref;
      href_d <= href;
      if (vref && !vref_d) odd_lat <= odd;
      if (!href) x_cnt <= '0;
      else if (32'(x_cnt) < H_ACTIVE) x_cnt <= x_cnt + 1'b1;
      pend <= pair_first;
      if (pair_first) begin
        y_lat  <= vpo[15:8];
        cb_lat <= vpo[7:0];
      end
      // held at zero between lines so it is already clear on href rise
      if (!href) x_out <= '0;
      else if (pair_fire) x_out <= x_out + 1'b1;
      if (state == ST_CLAIM) begin
        line_cnt <= '0;
        line_out <= '0;
      end else if (capturing && href_d && !href) begin
        if (32'(line_cnt) < V_ACTIVE) line_cnt <= line_cnt + 1'b1;
        if (line_keep) line_out <= line_out + 1'b1;
      end
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk_llc2 or negedge resetx) begin
    if (!resetx) begin
      buf_busy  <= '0;
      frame_rdy <= 1'b0;
      frame_err <= 1'b0;
      frame_idx <= '0;
      drop_cnt  <= '0;
      cur_idx   <= '0;
      last_idx  <= IDX_W'(NUM_BUF - 1);
    end else begin
      buf_busy  <= busy_eff | set_mask;
      frame_rdy <= done_ok;
      frame_err <= (state == ST_DONE) && !field_full;
      if (done_ok) begin
        frame_idx <= cur_idx;
        last_idx  <= cur_idx;
      end
      if (state == ST_CLAIM && parity_ok) begin
        if (found) cur_idx <= free_idx;
        else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_llc2 or negedge resetx) begin
    if (!resetx) addr_sr <= '0;
    else         addr_sr <= (PIPE_LAT * AW)'({addr_sr, addr_now});
  end
  assign wr_addr = addr_sr[PIPE_LAT-1];

`ifdef VCAP_RGB565_EN
  vcap_ycc2rgb565 u_ycc2rgb (
    .clk_llc2  (clk_llc2),
    .resetx    (resetx),
    .in_valid  (pair_fire),
    .y         (y_lat),
    .cb        (cb_lat),
    .cr        (vpo[7:0]),
    .out_valid (wr_en),
    .rgb       (wr_data)
  );
`else
  always_ff @(posedge clk_llc2 or negedge resetx) begin
    if (!resetx) begin
      wr_en   <= 1'b0;
      wr_data <= '0;
    end else begin
      wr_en <= pair_fire;
      if (pair_fire) wr_data <= {y_lat, cb_lat};
    end
  end
`endif

endmodule

// File: tb/tb_vcap_ring_scaler.sv
// Scoreboard bench for vcap_ring_scaler: directed fields, expected writes and
// frame events queued by the stimulus, popped by an independent monitor.
module tb_vcap_ring_scaler;

  localparam int H_ACTIVE = 16;
  localparam int V_ACTIVE = 8;
  localparam int H_DEC    = 4;
  localparam int V_DEC    = 2;
  localparam int NUM_BUF  = 3;
  localparam int LINE_PIX = 20;

  logic        clk_llc2 = 1'b0;
  logic        resetx = 1'b0;
  logic        vref = 1'b0, href = 1'b0, odd = 1'b0;
  logic [15:0] vpo = '0;
  logic        buf_rel = 1'b0;
  logic [1:0]  buf_rel_idx = '0;
  logic        wr_en, frame_rdy, frame_err, cap_active;
  logic [5:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  frame_idx;
  logic [2:0]  buf_busy;
  logic [7:0]  drop_cnt;

  vcap_ring_scaler #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_DEC(H_DEC), .V_DEC(V_DEC),
    .NUM_BUF(NUM_BUF), .FIELD_MODE(0)
  ) dut (
    .clk_llc2(clk_llc2), .resetx(resetx), .vref(vref), .href(href), .odd(odd),
    .vpo(vpo), .buf_rel(buf_rel), .buf_rel_idx(buf_rel_idx), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .frame_rdy(frame_rdy), .frame_idx(frame_idx),
    .frame_err(frame_err), .buf_busy(buf_busy), .drop_cnt(drop_cnt), .cap_active(cap_active)
  );

  always #5 clk_llc2 = ~clk_llc2;

  // colours: red, white, blue
  localparam int RED = 0, WHITE = 1, BLUE = 2;
  logic [7:0]  c_y  [3] = '{8'h51, 8'hEB, 8'h29};
  logic [7:0]  c_cb [3] = '{8'h5A, 8'h80, 8'hF0};
  logic [7:0]  c_cr [3] = '{8'hF0, 8'h80, 8'h6E};
  logic [15:0] e_raw[3] = '{16'h515A, 16'hEB80, 16'h29F0};
  logic [15:0] e_rgb[3] = '{16'hF800, 16'hFFFF, 16'h001F};

  typedef struct packed { logic [5:0] addr; logic [15:0] data; } wr_t;
  typedef struct packed { logic err; logic [1:0] idx; } ev_t;
  wr_t wq[$];
  ev_t eq[$];
  wr_t w;
  ev_t e;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_data(input int c);
`ifdef VCAP_RGB565_EN
    return e_rgb[c];
`else
    return e_raw[c];
`endif
  endfunction

  function automatic bit near(input int a, input int b);
    return (a - b <= 1) && (b - a <= 1);
  endfunction

  function automatic bit data_ok(input logic [15:0] a, input logic [15:0] x);
`ifdef VCAP_RGB565_EN
    return near(int'(a[15:11]), int'(x[15:11])) && near(int'(a[10:5]), int'(x[10:5])) &&
           near(int'(a[4:0]), int'(x[4:0]));
`else
    return a == x;
`endif
  endfunction

  // only pixel x%4==0 carries the pair's Y/Cb and x%4==1 its Cr; the rest is black
  function automatic logic [15:0] pix(input int x, input int c);
    case (x % 4)
      0:       return {c_y[c], c_cb[c]};
      1:       return {8'h10, c_cr[c]};
      default: return 16'h1080;
    endcase
  endfunction

  task automatic push_writes(input int idx, input int c, input int nkept);
    for (int l = 0; l < nkept; l++)
      for (int xo = 0; xo < 4; xo++)
        wq.push_back('{addr: 6'(idx * 16 + l * 4 + xo), data: exp_data(c)});
  endtask

  task automatic push_ev(input bit err, input int idx);
    eq.push_back('{err: err, idx: 2'(idx)});
  endtask

  task automatic run_field(input bit par, input int nlines, input int c,
                           input bit rel_claim, input logic [1:0] rel_idx);
    @(negedge clk_llc2); vref = 1'b1; odd = par;
    @(negedge clk_llc2);
    if (rel_claim) begin buf_rel = 1'b1; buf_rel_idx = rel_idx; end
    @(negedge clk_llc2); buf_rel = 1'b0;
    repeat (2) @(negedge clk_llc2);
    for (int l = 0; l < nlines; l++) begin
      for (int x = 0; x < LINE_PIX; x++) begin
        @(negedge clk_llc2); href = 1'b1; vpo = pix(x, c);
      end
      @(negedge clk_llc2); href = 1'b0; vpo = '0;
      repeat (3) @(negedge clk_llc2);
    end
    @(negedge clk_llc2); vref = 1'b0;
    repeat (10) @(negedge clk_llc2);
  endtask

  task automatic release_buf(input logic [1:0] idx);
    @(negedge clk_llc2); buf_rel = 1'b1; buf_rel_idx = idx;
    @(negedge clk_llc2); buf_rel = 1'b0;
  endtask

  always @(negedge clk_llc2) begin
    if (resetx && wr_en) begin
      if (wq.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, want no write", wr_addr, wr_data);
      end else begin
        w = wq.pop_front();
        check("wr_addr", int'(wr_addr), int'(w.addr));
        n_vec++;
        if (!data_ok(wr_data, w.data)) begin
          n_bad++;
          $display("FAIL wr_data @0x%0h: got 0x%0h want 0x%0h", w.addr, wr_data, w.data);
        end
      end
    end
    if (resetx && (frame_rdy || frame_err)) begin
      if (eq.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL frame_unexpected: got rdy=%0b err=%0b, want none", frame_rdy, frame_err);
      end else begin
        e = eq.pop_front();
        check("frame_err", int'(frame_err), int'(e.err));
        check("frame_rdy", int'(frame_rdy), int'(!e.err));
        if (!e.err) check("frame_idx_evt", int'(frame_idx), int'(e.idx));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_llc2);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_frame", int'({frame_rdy, frame_err, frame_idx}), 0);
    check("rst_busy", int'(buf_busy), 0);
    check("rst_drop", int'(drop_cnt), 0);
    check("rst_cap_active", int'(cap_active), 0);
    resetx = 1'b1;
    repeat (2) @(negedge clk_llc2);

    // red odd field into buffer 0
    push_writes(0, RED, 4); push_ev(0, 0);
    run_field(1'b1, 8, RED, 1'b0, 2'd0);
    check("t1_busy", int'(buf_busy), 3'b001);
    check("t1_frame_idx", int'(frame_idx), 0);

    // fill the ring, then one field with no free buffer
    push_writes(1, WHITE, 4); push_ev(0, 1);
    run_field(1'b1, 8, WHITE, 1'b0, 2'd0);
    check("t2_idx1", int'(frame_idx), 1);
    push_writes(2, BLUE, 4); push_ev(0, 2);
    run_field(1'b1, 8, BLUE, 1'b0, 2'd0);
    check("t2_idx2", int'(frame_idx), 2);
    check("t2_busy", int'(buf_busy), 3'b111);
    run_field(1'b1, 8, RED, 1'b0, 2'd0);
    check("t2_drop", int'(drop_cnt), 1);
    check("t2_busy_after_drop", int'(buf_busy), 3'b111);

    // release 1; releasing it again or an out-of-range index is ignored
    release_buf(2'd1);
    check("t3_busy_rel", int'(buf_busy), 3'b101);
    release_buf(2'd1);
    release_buf(2'd3);
    check("t3_busy_ign", int'(buf_busy), 3'b101);
    push_writes(1, BLUE, 4); push_ev(0, 1);
    run_field(1'b1, 10, BLUE, 1'b0, 2'd0);
    check("t3_frame_idx", int'(frame_idx), 1);
    check("t3_busy", int'(buf_busy), 3'b111);

    // even field is skipped without counting a drop
    run_field(1'b0, 8, WHITE, 1'b0, 2'd0);
    check("t4_drop", int'(drop_cnt), 1);

    // short field: partial writes, frame_err, buffer stays free
    release_buf(2'd2);
    push_writes(2, WHITE, 3); push_ev(1, 0);
    run_field(1'b1, 5, WHITE, 1'b0, 2'd0);
    check("t5_busy", int'(buf_busy), 3'b011);
    check("t5_frame_idx", int'(frame_idx), 1);

    // release in the CLAIM cycle with the ring full
    push_writes(2, RED, 4); push_ev(0, 2);
    run_field(1'b1, 8, RED, 1'b0, 2'd0);
    check("t6_busy_full", int'(buf_busy), 3'b111);
    push_writes(0, WHITE, 4); push_ev(0, 0);
    run_field(1'b1, 8, WHITE, 1'b1, 2'd0);
    check("t6_frame_idx", int'(frame_idx), 0);
    check("t6_drop", int'(drop_cnt), 1);
    check("t6_busy", int'(buf_busy), 3'b111);

    repeat (10) @(negedge clk_llc2);
    check("writes_pending", wq.size(), 0);
    check("events_pending", eq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
